rf_write_arbiter: RTL
=====================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of write data.
REQ-002 Parameter ADDR_W, default 5, width of register index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 a_valid  input  1  port A (ALU writeback) write request.
REQ-006 a_rd  input  ADDR_W  port A destination register.
REQ-007 a_data  input  DATA_W  port A write data.
REQ-008 a_ready  output  1  port A request accepted this cycle.
REQ-009 b_valid  input  1  port B (load writeback) write request.
REQ-010 b_rd  input  ADDR_W  port B destination register.
REQ-011 b_data  input  DATA_W  port B write data.
REQ-012 b_ready  output  1  port B request accepted this cycle.
REQ-013 hold  input  1  pipeline stall; blocks all grants while high.
REQ-014 rf_rd  output  ADDR_W  register file write index (to rf_32 rd).
REQ-015 rf_write_data  output  DATA_W  register file write data (to rf_32 write_data).
REQ-016 rf_write_enabled  output  1  register file write strobe (to rf_32 write_enabled).
REQ-017 prio  output  1  current round-robin priority: 0 = A, 1 = B.
REQ-018 drop_count  output  8  saturating count of accepted writes to register 0.

Function
REQ-019 Handshake: a request transfers on a rising edge where valid and ready are both high; at most one transfer per cycle.
REQ-020 a_ready/b_ready are combinational from a_valid, b_valid, hold, prio and SHALL never depend on the other port's ready.
REQ-021 hold high or rst high: a_ready = b_ready = 0.
REQ-022 Only one port valid, hold low: that port's ready = 1, regardless of prio.
REQ-023 Both valid, hold low: port named by prio gets ready = 1, the other 0.
REQ-024 ready SHALL be 0 for a port whose valid is 0.
REQ-025 Priority FSM, two states PRIO_A (prio=0) and PRIO_B (prio=1): on a transfer from A go to PRIO_B; on a transfer from B go to PRIO_A; no transfer holds state.
REQ-026 Requester holding valid SHALL keep rd/data stable until accepted; arbiter imposes no timeout.
REQ-027 Output stage registered: on the edge of a transfer, rf_rd and rf_write_data load the granted rd/data; rf_write_enabled loads 1 if granted rd != 0, else 0.
REQ-028 Latency: request accepted at edge N drives rf_write_enabled high during cycle N to N+1; rf_32 commits the value at edge N+1.
REQ-029 No transfer at an edge: rf_write_enabled loads 0; rf_rd and rf_write_data hold previous values.
REQ-030 Write to register 0 is accepted (ready asserted, handshake completes), never strobed to the file, and increments drop_count.
REQ-031 drop_count saturates at 255; no wrap-around.
REQ-032 Both ports targeting the same rd in the same cycle: served in priority order on consecutive transfers; later transfer's data is final register content.
REQ-033 Back-to-back transfers from one port permitted every cycle when the other port is idle.

Reset
REQ-034 rst high asynchronously forces rf_write_enabled = 0, rf_rd = 0, rf_write_data = 0, prio = 0 (PRIO_A), drop_count = 0.
REQ-035 Reset mid-operation: any pending strobe is cancelled immediately; no transfer occurs on any edge while rst is high.
REQ-036 First edge after rst deasserts SHALL arbitrate normally from PRIO_A.

Verification
REQ-037 Reset, then a_valid=1 a_rd=3 a_data=32'h22222222, b idle -> a_ready=1; next cycle rf_write_enabled=1 rf_rd=3 rf_write_data=32'h22222222; prio=1.
REQ-038 From reset, both valid (a_rd=5 a_data=32'h44444444, b_rd=6 b_data=32'h55555555) held -> A granted first, B on following edge; rf_write_enabled high two consecutive cycles; rf_32 reads r5=32'h44444444, r6=32'h55555555.
REQ-039 Both ports continuously valid for 8 cycles -> grants alternate A,B,A,B...; exactly 4 each; prio toggles every edge.
REQ-040 a_valid=1 a_rd=0 a_data=32'hDEADBEEF -> a_ready=1, rf_write_enabled stays 0, drop_count=1; rf_32 r0 unchanged; 260 such writes -> drop_count=255.
REQ-041 Both valid with hold=1 for 3 cycles -> both ready 0, rf_write_enabled 0, prio unchanged; hold drops -> prio port granted on next edge.
REQ-042 rst asserted mid-cycle while rf_write_enabled=1 -> rf_write_enabled falls immediately, prio=0, drop_count=0; rf_32 contents not modified by the cancelled strobe.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Purpose:
//   Arbitrates two writeback sources (port A: ALU, port B: load unit) onto the
//   single write port of a 32-entry register file. Uses a two-state
//   round-robin priority FSM for fairness. Drives a registered write stage:
//   a request accepted at edge N presents rf_write_enabled/rf_rd/rf_write_data
//   during cycle N..N+1, and the register file commits at edge N+1.
//   Writes that target register 0 complete their handshake but are never
//   strobed. They are tallied instead in a saturating 8-bit counter.
//
// Ports:
//   clk              in   single clock, rising-edge state updates
//   rst              in   asynchronous, active-high reset
//   a_valid/a_rd/a_data   in   port A write request, index, data
//   a_ready          out  port A accepted this cycle (combinational)
//   b_valid/b_rd/b_data   in   port B write request, index, data
//   b_ready          out  port B accepted this cycle (combinational)
//   hold             in   pipeline stall, blocks all grants while high
//   rf_rd            out  register file write index (registered)
//   rf_write_data    out  register file write data (registered)
//   rf_write_enabled out  register file write strobe (registered)
//   prio             out  round-robin priority, 0 = A, 1 = B
//   drop_count       out  saturating count of accepted writes to register 0
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              hold,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_enabled,
  output logic              prio,
  output logic [7:0]        drop_count
);

  // Priority FSM encoding; the state value is exported directly as prio.
  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

  localparam logic [7:0]        DROP_MAX  = 8'd255;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  // State flops and their next-state values
  logic              prio_q,             prio_d;
  logic [ADDR_W-1:0] rf_rd_q,            rf_rd_d;
  logic [DATA_W-1:0] rf_write_data_q,    rf_write_data_d;
  logic              rf_write_enabled_q, rf_write_enabled_d;
  logic [7:0]        drop_count_q,       drop_count_d;

  // Combinational handshake and grant signals
  logic              a_ready_s;
  logic              b_ready_s;
  logic              a_fire_s;
  logic              b_fire_s;
  logic              xfer_s;
  logic [ADDR_W-1:0] grant_rd_s;
  logic [DATA_W-1:0] grant_data_s;

  // Ready generation: each ready is derived from both valids, hold, rst and
  // prio only, so neither ready ever feeds back through the other.
  always_comb begin
    a_ready_s = 1'b0;
    b_ready_s = 1'b0;
    if (rst || hold) begin
      a_ready_s = 1'b0;
      b_ready_s = 1'b0;
    end else begin
      case ({a_valid, b_valid})
        2'b10: begin
          a_ready_s = 1'b1;
          b_ready_s = 1'b0;
        end
        2'b01: begin
          a_ready_s = 1'b0;
          b_ready_s = 1'b1;
        end
        2'b11: begin
          // Contention: the priority holder wins, the other waits.
          if (prio_q == PRIO_B) begin
            a_ready_s = 1'b0;
            b_ready_s = 1'b1;
          end else begin
            a_ready_s = 1'b1;
            b_ready_s = 1'b0;
          end
        end
        default: begin
          a_ready_s = 1'b0;
          b_ready_s = 1'b0;
        end
      endcase
    end
  end

  // Transfer detection; at most one of the two can be high by construction.
  always_comb begin
    a_fire_s = a_valid & a_ready_s;
    b_fire_s = b_valid & b_ready_s;
    xfer_s   = a_fire_s | b_fire_s;
  end

  // Grant mux: selects the winning port's index/data, or the current output
  // stage contents when nothing transfers so those outputs hold.
  always_comb begin
    grant_rd_s   = rf_rd_q;
    grant_data_s = rf_write_data_q;
    if (a_fire_s) begin
      grant_rd_s   = a_rd;
      grant_data_s = a_data;
    end else if (b_fire_s) begin
      grant_rd_s   = b_rd;
      grant_data_s = b_data;
    end else begin
      grant_rd_s   = rf_rd_q;
      grant_data_s = rf_write_data_q;
    end
  end

  // Priority FSM next state: the port that just won hands priority over.
  always_comb begin
    prio_d = prio_q;
    case ({a_fire_s, b_fire_s})
      2'b10:   prio_d = PRIO_B;
      2'b01:   prio_d = PRIO_A;
      default: prio_d = prio_q;
    endcase
  end

  // Output stage next state: a register-0 write still loads rd/data but
  // never raises the strobe.
  always_comb begin
    rf_rd_d            = grant_rd_s;
    rf_write_data_d    = grant_data_s;
    rf_write_enabled_d = 1'b0;
    if (xfer_s && (grant_rd_s != ZERO_ADDR)) begin
      rf_write_enabled_d = 1'b1;
    end else begin
      rf_write_enabled_d = 1'b0;
    end
  end

  // Dropped-write counter next state, saturating at its maximum.
  always_comb begin
    drop_count_d = drop_count_q;
    if (xfer_s && (grant_rd_s == ZERO_ADDR) && (drop_count_q != DROP_MAX)) begin
      drop_count_d = drop_count_q + 8'd1;
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  // State registers; reset cancels any pending strobe immediately and
  // restarts arbitration from PRIO_A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q             <= PRIO_A;
      rf_rd_q            <= ZERO_ADDR;
      rf_write_data_q    <= ZERO_DATA;
      rf_write_enabled_q <= 1'b0;
      drop_count_q       <= 8'd0;
    end else begin
      prio_q             <= prio_d;
      rf_rd_q            <= rf_rd_d;
      rf_write_data_q    <= rf_write_data_d;
      rf_write_enabled_q <= rf_write_enabled_d;
      drop_count_q       <= drop_count_d;
    end
  end

  // Output assignments
  assign a_ready          = a_ready_s;
  assign b_ready          = b_ready_s;
  assign prio             = prio_q;
  assign rf_rd            = rf_rd_q;
  assign rf_write_data    = rf_write_data_q;
  assign rf_write_enabled = rf_write_enabled_q;
  assign drop_count       = drop_count_q;

endmodule
